// File: rtl/snn_conv_pkg.sv
// Shared types and helpers for the SNN event-driven convolution path.
// Holds coordinate packing, default parameters, saturating arithmetic
// and kernel-position-to-offset mapping.
package snn_conv_pkg;

   localparam int unsigned DEF_COORD_BITS  = 8;
   localparam int unsigned DEF_IMG_WIDTH   = 32;
   localparam int unsigned DEF_IMG_HEIGHT  = 32;
   localparam int unsigned DEF_CHANNELS    = 1;
   localparam int unsigned DEF_NEURON_BITS = 9;
   localparam int unsigned DEF_KERNEL_BITS = 6;
   localparam int unsigned DEF_KERNEL_SIZE = 3;

   // Coordinates and offsets travel as wide signed pairs; callers truncate
   // to their own arithmetic width (coordinates up to 14 bits fit).
   localparam int unsigned VEC_BITS = 16;

   typedef struct packed {
      logic signed [VEC_BITS-1:0] x;
      logic signed [VEC_BITS-1:0] y;
   } vec2_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_UPDATE,
      ST_WRITE
   } state_t;

   // {x,y} with x in the upper cb bits
   function automatic logic [31:0] pack_coord(input vec2_t v, input int unsigned cb);
      logic [31:0] mask;
      mask = (32'd1 << cb) - 32'd1;
      return ((32'(v.x) & mask) << cb) | (32'(v.y) & mask);
   endfunction

   function automatic vec2_t unpack_coord(input logic [31:0] c, input int unsigned cb);
      vec2_t       v;
      logic [31:0] mask;
      mask = (32'd1 << cb) - 32'd1;
      v.x  = 16'((c >> cb) & mask);
      v.y  = 16'(c & mask);
      return v;
   endfunction

   // Row-major kernel position to (dx,dy) centred on the event
   function automatic vec2_t pos_offset(input int unsigned p, input int unsigned k);
      vec2_t v;
      int    r;
      r   = int'((k - 1) / 2);
      v.x = 16'(int'(p % k) - r);
      v.y = 16'(int'(p / k) - r);
      return v;
   endfunction

   function automatic logic signed [32:0] wide_sum(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
      return {a[31], a} + {b[31], b};
   endfunction

   // Signed add clamped to an nb-bit two's complement range
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int unsigned nb);
      logic signed [32:0] sum, hi, lo;
      sum = wide_sum(a, b);
      hi  = (33'sd1 <<< (nb - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (nb - 1));
      if (sum > hi) return 32'(hi);
      if (sum < lo) return 32'(lo);
      return 32'(sum);
   endfunction

   function automatic logic sat_hit(input logic signed [31:0] a,
                                    input logic signed [31:0] b,
                                    input int unsigned nb);
      logic signed [32:0] sum, hi, lo;
      sum = wide_sum(a, b);
      hi  = (33'sd1 <<< (nb - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (nb - 1));
      return (sum > hi) || (sum < lo);
   endfunction

endpackage

// File: rtl/kernel_weight_bank.sv
// Kernel weight register array: K*K positions x CHANNELS signed weights.
// Writes are accepted only while the gate is open; read is combinational.
module kernel_weight_bank #(
   parameter int unsigned POSITIONS   = 9,
   parameter int unsigned CHANNELS    = 1,
   parameter int unsigned KERNEL_BITS = 6,
   parameter int unsigned PW          = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic                            wr_gate,
   input  logic [PW-1:0]                   wr_addr,
   input  logic [CHANNELS*KERNEL_BITS-1:0] wr_data,
   input  logic [PW-1:0]                   rd_addr,
   output logic [CHANNELS*KERNEL_BITS-1:0] rd_data
);

   logic [CHANNELS*KERNEL_BITS-1:0] bank [POSITIONS];

   // Gated weight write; reset clears every position
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < POSITIONS; i++) bank[i] <= '0;
      end else if (wr_en && wr_gate && (int'(wr_addr) < int'(POSITIONS))) begin
         bank[wr_addr] <= wr_data;
      end
   end

   // Weight lookup for the current kernel position
   always_comb begin
      rd_data = '0;
      if (int'(rd_addr) < int'(POSITIONS)) rd_data = bank[rd_addr];
   end

endmodule

// File: rtl/event_kernel_accumulator.sv
// Event-driven K x K kernel scatter onto the membrane-potential map with
// per-channel saturating read-modify-write and image-boundary clipping.
// Optional saturation counter: define SATURATION_COUNT_EN.
module event_kernel_accumulator
   import snn_conv_pkg::*;
#(
   parameter int unsigned COORD_BITS  = DEF_COORD_BITS,
   parameter int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int unsigned CHANNELS    = DEF_CHANNELS,
   parameter int unsigned NEURON_BITS = DEF_NEURON_BITS,
   parameter int unsigned KERNEL_BITS = DEF_KERNEL_BITS,
   parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
   localparam int unsigned POSITIONS  = KERNEL_SIZE * KERNEL_SIZE,
   localparam int unsigned PW         = (POSITIONS > 1) ? $clog2(POSITIONS) : 1,
   localparam int unsigned AW         = (IMG_WIDTH * IMG_HEIGHT > 1) ?
                                        $clog2(IMG_WIDTH * IMG_HEIGHT) : 1,
   localparam int unsigned FW         = CHANNELS * NEURON_BITS,
   localparam int unsigned WW         = CHANNELS * KERNEL_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    event_valid,
   output logic                    event_ready,
   input  logic [2*COORD_BITS-1:0] event_coord,
   output logic                    event_done,
   input  logic                    w_wr_en,
   input  logic [PW-1:0]           w_wr_addr,
   input  logic [WW-1:0]           w_wr_data,
   output logic                    fm_rd_en,
   output logic [AW-1:0]           fm_rd_addr,
   input  logic [FW-1:0]           fm_rd_data,
   output logic                    fm_wr_en,
   output logic [AW-1:0]           fm_wr_addr,
   output logic [FW-1:0]           fm_wr_data,
   output logic [15:0]             sat_count
);

   localparam int unsigned CW = COORD_BITS + 2;

   state_t                  state;
   logic [PW-1:0]           p;
   logic [2*COORD_BITS-1:0] coord_q;
   logic                    ready_q, done_q, rd_en_q, wr_en_q;
   logic [AW-1:0]           rd_addr_q, wr_addr_q;
   logic [FW-1:0]           wr_data_q;

   logic [PW-1:0]           look_p;
   logic [2*COORD_BITS-1:0] look_coord;
   logic                    look_inb;
   logic [AW-1:0]           look_addr;
   logic                    last;
   logic [WW-1:0]           w_cur;
   logic [FW-1:0]           upd_data;

   kernel_weight_bank #(
      .POSITIONS  (POSITIONS),
      .CHANNELS   (CHANNELS),
      .KERNEL_BITS(KERNEL_BITS),
      .PW         (PW)
   ) u_weights (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (w_wr_en),
      .wr_gate(ready_q),
      .wr_addr(w_wr_addr),
      .wr_data(w_wr_data),
      .rd_addr(p),
      .rd_data(w_cur)
   );

   assign last = (p == PW'(POSITIONS - 1));

   // Bounds and address of the position the FSM visits next, so that the
   // read strobe can be registered on entry to ADDR rather than decoded.
   always_comb begin
      vec2_t                c, off;
      logic signed [CW-1:0] tx, ty;
      look_p     = (state == ST_IDLE) ? '0 : p + PW'(1);
      look_coord = (state == ST_IDLE) ? event_coord : coord_q;
      c          = unpack_coord(32'(look_coord), COORD_BITS);
      off        = pos_offset(int'(look_p), KERNEL_SIZE);
      tx         = CW'(c.x) + CW'(off.x);
      ty         = CW'(c.y) + CW'(off.y);
      look_inb   = (int'(tx) >= 0) && (int'(tx) < int'(IMG_WIDTH)) &&
                   (int'(ty) >= 0) && (int'(ty) < int'(IMG_HEIGHT));
      look_addr  = look_inb ? AW'(int'(ty) * int'(IMG_WIDTH) + int'(tx)) : '0;
   end

   // Per-channel saturating update of the returned potentials
   always_comb begin
      upd_data = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         upd_data[ch*NEURON_BITS +: NEURON_BITS] = NEURON_BITS'(sat_add(
            32'($signed(fm_rd_data[ch*NEURON_BITS +: NEURON_BITS])),
            32'($signed(w_cur[ch*KERNEL_BITS +: KERNEL_BITS])), NEURON_BITS));
      end
   end

`ifdef SATURATION_COUNT_EN
   logic [CHANNELS-1:0] upd_sat, sat_mask_q;
   logic [15:0]         sat_cnt_q, sat_next;

   // Which channels clamp in this update
   always_comb begin
      upd_sat = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         upd_sat[ch] = sat_hit(
            32'($signed(fm_rd_data[ch*NEURON_BITS +: NEURON_BITS])),
            32'($signed(w_cur[ch*KERNEL_BITS +: KERNEL_BITS])), NEURON_BITS);
      end
   end

   // Counter plus clamps of the write in flight, pinned at all-ones
   always_comb begin
      logic [15:0] inc;
      logic [16:0] sum;
      inc = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) inc = inc + 16'(sat_mask_q[ch]);
      sum      = {1'b0, sat_cnt_q} + {1'b0, inc};
      sat_next = sum[16] ? '1 : sum[15:0];
   end

   // Saturation counter advances on each WRITE cycle
   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else if (wr_en_q) sat_cnt_q <= sat_next;
   end

   assign sat_count = sat_cnt_q;
`else
   assign sat_count = '0;
`endif

   // Event sequencing FSM: IDLE -> (ADDR [-> UPDATE -> WRITE])* -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         p         <= '0;
         coord_q   <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef SATURATION_COUNT_EN
         sat_mask_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (event_valid && ready_q) begin
                  state     <= ST_ADDR;
                  coord_q   <= event_coord;
                  p         <= '0;
                  ready_q   <= 1'b0;
                  rd_en_q   <= look_inb;
                  rd_addr_q <= look_addr;
               end
            end
            ST_ADDR: begin
               if (rd_en_q) begin
                  rd_en_q <= 1'b0;
                  state   <= ST_UPDATE;
               end else if (last) begin
                  state   <= ST_IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
               end else begin
                  p         <= p + PW'(1);
                  rd_en_q   <= look_inb;
                  rd_addr_q <= look_addr;
               end
            end
            ST_UPDATE: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= rd_addr_q;
               wr_data_q <= upd_data;
`ifdef SATURATION_COUNT_EN
               sat_mask_q <= upd_sat;
`endif
               state     <= ST_WRITE;
            end
            ST_WRITE: begin
               wr_en_q <= 1'b0;
               if (last) begin
                  state   <= ST_IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
               end else begin
                  state     <= ST_ADDR;
                  p         <= p + PW'(1);
                  rd_en_q   <= look_inb;
                  rd_addr_q <= look_addr;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign event_ready = ready_q;
   assign event_done  = done_q;
   assign fm_rd_en    = rd_en_q;
   assign fm_rd_addr  = rd_addr_q;
   assign fm_wr_en    = wr_en_q;
   assign fm_wr_addr  = wr_addr_q;
   assign fm_wr_data  = wr_data_q;

endmodule

// File: tb/tb_event_kernel_accumulator.sv
// Scoreboard bench for event_kernel_accumulator (3x3, 1 channel, 32x32 map).
module tb_event_kernel_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        event_valid = 1'b0;
   logic        event_ready;
   logic [15:0] event_coord = '0;
   logic        event_done;
   logic        w_wr_en = 1'b0;
   logic [3:0]  w_wr_addr = '0;
   logic [5:0]  w_wr_data = '0;
   logic        fm_rd_en;
   logic [9:0]  fm_rd_addr;
   logic [8:0]  fm_rd_data = '0;
   logic        fm_wr_en;
   logic [9:0]  fm_wr_addr;
   logic [8:0]  fm_wr_data;
   logic [15:0] sat_count;

   event_kernel_accumulator #(
      .COORD_BITS(8), .IMG_WIDTH(32), .IMG_HEIGHT(32), .CHANNELS(1),
      .NEURON_BITS(9), .KERNEL_BITS(6), .KERNEL_SIZE(3)
   ) dut (
      .clk(clk), .rst(rst), .event_valid(event_valid), .event_ready(event_ready),
      .event_coord(event_coord), .event_done(event_done), .w_wr_en(w_wr_en),
      .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .fm_rd_en(fm_rd_en),
      .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data), .fm_wr_en(fm_wr_en),
      .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   // Feature-map memory seen by the DUT
   logic signed [8:0] mem [1024];
   int cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];
      if (fm_wr_en) mem[fm_wr_addr] = fm_wr_data;
   end

   // Reference model state
   int model_mem [1024];
   int wmodel [9];
   int exp_sat = 0;
   typedef struct { int addr; int data; int old; } wr_t;
   typedef struct { int cyc; int sat; } dn_t;
   wr_t wq[$];
   dn_t dq[$];

   int checks = 0, passes = 0, wr_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: actual %0d required %0d", name, act, exp);
   endtask

   function automatic int clamp9(input int s);
      if (s > 255) return 255;
      if (s < -256) return -256;
      return s;
   endfunction

   // Scatter rule evaluated directly: every in-bounds neighbour gets w[p] added
   task automatic model_event(input int x, input int y, input int acc);
      int cost = 0;
      for (int p = 0; p < 9; p++) begin
         int tx = x + (p % 3) - 1;
         int ty = y + (p / 3) - 1;
         if (tx >= 0 && tx < 32 && ty >= 0 && ty < 32) begin
            int a = ty * 32 + tx;
            int old = model_mem[a];
            int s = old + wmodel[p];
            int c = clamp9(s);
            if (c != s && exp_sat < 65535) exp_sat++;
            wq.push_back('{a, c, old});
            model_mem[a] = c;
            cost += 3;
         end else begin
            cost += 1;
         end
      end
`ifdef SATURATION_COUNT_EN
      dq.push_back('{acc + 1 + cost, exp_sat});
`else
      dq.push_back('{acc + 1 + cost, 0});
`endif
   endtask

   // Monitor: compare every presented write and every done pulse
   always @(negedge clk) begin
      if (fm_wr_en) begin
         wr_seen++;
         if (wq.size() == 0) check("unexpected_write", int'(fm_wr_addr), -1);
         else begin
            wr_t e;
            e = wq.pop_front();
            check("wr_addr", int'(fm_wr_addr), e.addr);
            check("wr_data", int'($signed(fm_wr_data)), e.data);
         end
      end
      if (event_done) begin
         if (dq.size() == 0) check("unexpected_done", 1, 0);
         else begin
            dn_t d;
            d = dq.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("sat_count", int'(sat_count), d.sat);
            check("ready_with_done", int'(event_ready), 1);
         end
      end
   end

   task automatic send_event(input int x, input int y, input bit hold, output bit in_done);
      int n = 0;
      in_done = 1'b0;
      @(negedge clk);
      event_valid = 1'b1;
      event_coord = {8'(x), 8'(y)};
      while (!event_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!event_ready) begin
         check("accept_timeout", 0, 1);
         event_valid = 1'b0;
         return;
      end
      in_done = event_done;
      model_event(x, y, cyc);
      @(posedge clk);
      #1;
      if (!hold) event_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      event_valid = 1'b0;
      while (!(wq.size() == 0 && dq.size() == 0 && event_ready) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600) begin
         check("idle_timeout", 0, 1);
         wq.delete();
         dq.delete();
      end
   endtask

   task automatic load_weights(input int ws [9]);
      for (int p = 0; p < 9; p++) begin
         @(negedge clk);
         w_wr_en = 1'b1;
         w_wr_addr = 4'(p);
         w_wr_data = 6'(ws[p]);
         wmodel[p] = ws[p];
      end
      @(negedge clk);
      w_wr_en = 1'b0;
   endtask

   task automatic zero_mem();
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0;
         model_mem[i] = 0;
      end
   endtask

   task automatic do_reset();
      wr_t e;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      while (wq.size() > 0) begin
         e = wq.pop_back();
         model_mem[e.addr] = e.old;
      end
      dq.delete();
      for (int p = 0; p < 9; p++) wmodel[p] = 0;
      exp_sat = 0;
      event_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", int'(event_ready), 1);
      check("post_rst_done", int'(event_done), 0);
      check("post_rst_rd_en", int'(fm_rd_en), 0);
      check("post_rst_wr_en", int'(fm_wr_en), 0);
      check("post_rst_sat", int'(sat_count), 0);
   endtask

   initial begin
      int  sobel [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
      int  rw [9];
      bit  f;
      int  base, n, extra;
      zero_mem();
      repeat (3) @(negedge clk);
      check("rst_ready", int'(event_ready), 1);
      check("rst_done", int'(event_done), 0);
      check("rst_rd_en", int'(fm_rd_en), 0);
      check("rst_wr_en", int'(fm_wr_en), 0);
      check("rst_rd_addr", int'(fm_rd_addr), 0);
      check("rst_wr_addr", int'(fm_wr_addr), 0);
      check("rst_wr_data", int'(fm_wr_data), 0);
      check("rst_sat", int'(sat_count), 0);
      rst = 1'b0;

      // Interior event and corner-clipped event
      load_weights(sobel);
      send_event(5, 5, 1'b0, f);
      wait_idle();
      check("interior_197", int'(mem[197]), -2);
      zero_mem();
      send_event(0, 0, 1'b0, f);
      wait_idle();
      check("corner_32", int'(mem[32]), -2);

      // Saturation at both rails
      zero_mem();
      mem[133] = 9'sd255;   model_mem[133] = 255;
      mem[197] = -9'sd255;  model_mem[197] = -255;
      send_event(5, 5, 1'b0, f);
      wait_idle();
      check("sat_pos_133", int'(mem[133]), 255);
      check("sat_neg_197", int'(mem[197]), -256);

      // Held second event is taken in the done cycle of the first
      zero_mem();
      send_event(5, 5, 1'b1, f);
      send_event(6, 7, 1'b0, f);
      check("b2b_accept_in_done", int'(f), 1);
      wait_idle();

      // Weight write while busy is ignored
      zero_mem();
      send_event(10, 10, 1'b0, f);
      repeat (5) begin
         @(negedge clk);
         w_wr_en = 1'b1; w_wr_addr = 4'd1; w_wr_data = 6'd5;
      end
      @(negedge clk);
      w_wr_en = 1'b0;
      wait_idle();
      send_event(20, 20, 1'b0, f);
      wait_idle();
      check("busy_wr_ignored", int'(mem[628]), 2);

      // Randomized events over random memory and weights
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 9'(int'($urandom_range(0, 511)) - 256);
         model_mem[i] = int'($signed(mem[i]));
      end
      for (int i = 0; i < 24; i++) begin
         int x, y;
         bit hold;
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            for (int p = 0; p < 9; p++) rw[p] = int'($urandom_range(0, 63)) - 32;
            load_weights(rw);
         end
         x = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 34));
         y = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 34));
         hold = 1'($urandom_range(0, 1));
         send_event(x, y, hold, f);
         if (!hold) wait_idle();
      end
      wait_idle();

      // Reset after the second write of an event
      load_weights(sobel);
      zero_mem();
      base = wr_seen;
      send_event(5, 5, 1'b0, f);
      n = 0;
      while (wr_seen < base + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_event_two_writes", wr_seen - base, 2);
      do_reset();
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (fm_wr_en || fm_rd_en) extra++;
      end
      check("post_rst_no_access", extra, 0);
      send_event(5, 5, 1'b0, f);
      wait_idle();
      check("weights_cleared_133", int'(mem[133]), 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
